shift_bcd_unit: RTL and testbench

//  Registered shift datapath plus a binary-to-BCD converter, for the ALU display path.
//  - Shifts din logically or arithmetically, by one bit, left or right.
//  - Converts the unsigned shift result to packed BCD using iterative double-dabble
//    (shift-and-add-3).
//  - Talks to the controller through a start/busy/done handshake.

---
 rtl/shift_bcd_unit.sv | 205 ++++++++++++++++++++
 tb/tb_shift_bcd_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_bcd_unit.sv
// -----------------------------------------------------------------------------
// shift_bcd_unit
//   Registered one-bit shifter followed by an iterative binary-to-BCD converter
//   (double-dabble, shift-and-add-3) feeding the ALU display path.
//
//   Optional build macro: SSD_DISPLAY_EN
//     When defined, adds active-low seven-segment outputs hex2..hex0 (abcdefg)
//     loaded together with bcd_out. When undefined, those ports do not exist.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous active-low reset
//   start      in   1          conversion request, taken only while busy=0
//   op_sel     in   2          00/11 pass-through, 01 logical, 10 arithmetic
//   dir        in   1          1 = shift left, 0 = shift right
//   din        in   DWIDTH     operand, sampled only on the accept edge
//   shift_out  out  DWIDTH     registered shift result
//   bcd_out    out  4*DIGITS   packed BCD of shift_out, digit0 in [3:0]
//   busy       out  1          conversion in progress
//   done       out  1          single-cycle pulse, bcd_out valid from here on
//   hex2..hex0 out  7 each     segment codes (SSD_DISPLAY_EN only)
// -----------------------------------------------------------------------------
module shift_bcd_unit #(
  parameter int DWIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op_sel,
  input  logic                  dir,
  input  logic [DWIDTH-1:0]     din,
  output logic [DWIDTH-1:0]     shift_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
`ifdef SSD_DISPLAY_EN
  ,
  output logic [6:0]            hex2,
  output logic [6:0]            hex1,
  output logic [6:0]            hex0
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] shift_out_q, shift_out_d;
  logic [BW-1:0]     bcd_out_q, bcd_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DWIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]     bcd_work_q, bcd_work_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DWIDTH-1:0] shift_res;
  logic [BW-1:0]     bcd_adj;

  // One-bit shift of din. Arithmetic left keeps the sign bit and drops the
  // bit just below it; arithmetic right replicates the sign bit.
  always_comb begin
    shift_res = din;
    case (op_sel)
      2'b01: shift_res = dir ? {din[DWIDTH-2:0], 1'b0}
                             : {1'b0, din[DWIDTH-1:1]};
      2'b10: shift_res = dir ? {din[DWIDTH-1], din[DWIDTH-3:0], 1'b0}
                             : {din[DWIDTH-1], din[DWIDTH-1:1]};
      default: shift_res = din;
    endcase
  end

  // Add-3 correction on every nibble that would overflow past 9 after the
  // following doubling.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_work_q[4*gi +: 4] >= 4'd5)
                                  ? bcd_work_q[4*gi +: 4] + 4'd3
                                  : bcd_work_q[4*gi +: 4];
    end
  endgenerate

`ifdef SSD_DISPLAY_EN
  logic [6:0] hex2_q, hex2_d;
  logic [6:0] hex1_q, hex1_d;
  logic [6:0] hex0_q, hex0_d;

  // Zero-extend so digits 2..0 exist regardless of DIGITS.
  logic [BW+11:0] bcd_ext;
  assign bcd_ext = {12'd0, bcd_work_q};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    shift_out_d = shift_out_q;
    bcd_out_d   = bcd_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bin_d       = bin_q;
    bcd_work_d  = bcd_work_q;
    cnt_d       = cnt_q;
`ifdef SSD_DISPLAY_EN
    hex2_d      = hex2_q;
    hex1_d      = hex1_q;
    hex0_d      = hex0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          shift_out_d = shift_res;
          bin_d       = shift_res;
          bcd_work_d  = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        // {bcd,bin} shifted left by one after correction.
        bcd_work_d = {bcd_adj[BW-2:0], bin_q[DWIDTH-1]};
        bin_d      = {bin_q[DWIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(DWIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Outputs are registered here, so done/busy change on the edge that
        // leaves this state; the next start is then taken from IDLE.
        bcd_out_d = bcd_work_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
`ifdef SSD_DISPLAY_EN
        hex2_d    = seg7(bcd_ext[11:8]);
        hex1_d    = seg7(bcd_ext[7:4]);
        hex0_d    = seg7(bcd_ext[3:0]);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_out_q <= '0;
      bcd_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bin_q       <= '0;
      bcd_work_q  <= '0;
      cnt_q       <= '0;
`ifdef SSD_DISPLAY_EN
      hex2_q      <= 7'b1111111;
      hex1_q      <= 7'b1111111;
      hex0_q      <= 7'b1111111;
`endif
    end else begin
      state_q     <= state_d;
      shift_out_q <= shift_out_d;
      bcd_out_q   <= bcd_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bin_q       <= bin_d;
      bcd_work_q  <= bcd_work_d;
      cnt_q       <= cnt_d;
`ifdef SSD_DISPLAY_EN
      hex2_q      <= hex2_d;
      hex1_q      <= hex1_d;
      hex0_q      <= hex0_d;
`endif
    end
  end

  assign shift_out = shift_out_q;
  assign bcd_out   = bcd_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SSD_DISPLAY_EN
  assign hex2      = hex2_q;
  assign hex1      = hex1_q;
  assign hex0      = hex0_q;
`endif

endmodule

// File: tb/tb_shift_bcd_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_bcd_unit
//   Directed self-checking bench for shift_bcd_unit (DWIDTH=8, DIGITS=3).
//   Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_shift_bcd_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_sel;
  logic        dir;
  logic [7:0]  din;
  logic [7:0]  shift_out;
  logic [11:0] bcd_out;
  logic        busy;
  logic        done;
`ifdef SSD_DISPLAY_EN
  logic [6:0]  hex2, hex1, hex0;
`endif

  int tests;
  int fails;
  int lat;
  int seen;

  shift_bcd_unit #(.DWIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sel    (op_sel),
    .dir       (dir),
    .din       (din),
    .shift_out (shift_out),
    .bcd_out   (bcd_out),
    .busy      (busy),
    .done      (done)
`ifdef SSD_DISPLAY_EN
    ,
    .hex2      (hex2),
    .hex1      (hex1),
    .hex0      (hex0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one conversion from an idle point, then wait for done (bounded).
  task automatic run(input string tag, input logic [7:0] d, input logic [1:0] op,
                     input logic dr, input logic [7:0] exp_shift, input logic [11:0] exp_bcd);
    din    = d;
    op_sel = op;
    dir    = dr;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
    din    = ~d;            // operand must not matter after the accept edge
    op_sel = ~op;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_shift"}, shift_out, exp_shift);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_bcd"}, bcd_out, exp_bcd);
    chk({tag, "_busy_at_done"}, busy, 0);
    $display("[TB] %s din=%h op=%b dir=%b shift=%h bcd=%h lat=%0d",
             tag, d, op, dr, shift_out, bcd_out, lat);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sel = 2'b00;
    dir    = 1'b0;
    din    = 8'h00;

    // 1. reset, then idle with no start
    repeat (3) cyc();
    chk("rst_shift", shift_out, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SSD_DISPLAY_EN
    chk("rst_hex0", hex0, 7'b1111111);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_shift", shift_out, 0);
      chk("idle_bcd", bcd_out, 0);
      chk("idle_busy_done", {busy, done}, 0);
    end
    $display("[TB] reset/idle checked");

    // 2. logical right
    run("lsr", 8'hB5, 2'b01, 1'b0, 8'h5A, 12'h090);
    cyc();
    chk("lsr_done_single", done, 0);
    chk("lsr_bcd_hold", bcd_out, 12'h090);

    // 3. arithmetic right, then arithmetic left started in the done cycle
    run("asr", 8'hB5, 2'b10, 1'b0, 8'hDA, 12'h218);
`ifdef SSD_DISPLAY_EN
    chk("asr_hex2", hex2, 7'b0010010);
    chk("asr_hex1", hex1, 7'b1001111);
    chk("asr_hex0", hex0, 7'b0000000);
`endif
    run("asl", 8'hB5, 2'b10, 1'b1, 8'hEA, 12'h234);
    cyc();
    chk("asl_done_single", done, 0);

    // 4. pass-through extremes and logical left
    run("pass_ff", 8'hFF, 2'b00, 1'b0, 8'hFF, 12'h255);
    run("pass_00", 8'h00, 2'b11, 1'b1, 8'h00, 12'h000);
    run("lsl", 8'hB5, 2'b01, 1'b1, 8'h6A, 12'h106);
    cyc();

    // 5a. start while busy is ignored
    din = 8'hFF; op_sel = 2'b00; dir = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    din = 8'h01; op_sel = 2'b01; dir = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_busy", busy, 1);
    chk("ign_shift", shift_out, 8'hFF);
    lat = 0;
    for (int k = 5; k <= 20; k++) begin
      cyc();
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ign_latency", lat, 9);
    chk("ign_bcd", bcd_out, 12'h255);
    chk("ign_shift_hold", shift_out, 8'hFF);
    $display("[TB] ignored-start shift=%h bcd=%h lat=%0d", shift_out, bcd_out, lat);
    cyc();
    chk("ign_no_second", busy, 0);

    // 5b. reset in the middle of a conversion
    din = 8'h7F; op_sel = 2'b00; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    chk("abort_shift", shift_out, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_bcd_stay", bcd_out, 0);
    $display("[TB] abort checked, activity=%0d", seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
